perceptron_trainer: RTL

- Sequential training engine for the 2-input step-activation perceptron; the learning direction of the inference datapath.
- Accepts labelled samples over a valid/ready stream and applies the perceptron learning rule to w1, w2 and bias.
- Counts misclassifications per epoch and stops on convergence or after an epoch limit.
- Trained weights feed the inference perceptron instances of the MLP.

---
 rtl/perceptron_trainer.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/perceptron_trainer.sv
// Sequential trainer for a 2-input step-activation perceptron using the perceptron learning rule.
// Optional: define PERCEPTRON_TRAINER_SAT_EN to saturate weight/bias updates instead of wrapping.
module perceptron_trainer #(
    parameter int W          = 10,
    parameter int LR_SHIFT   = 0,
    parameter int EPOCH_LEN  = 4,
    parameter int MAX_EPOCHS = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic signed [W-1:0] init_w1,
    input  logic signed [W-1:0] init_w2,
    input  logic signed [W-1:0] init_bias,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic signed [W-1:0] s_x1,
    input  logic signed [W-1:0] s_x2,
    input  logic                s_target,
    output logic signed [W-1:0] w1,
    output logic signed [W-1:0] w2,
    output logic signed [W-1:0] bias,
    output logic                busy,
    output logic                epoch_done,
    output logic [7:0]          epoch_errors,
    output logic [7:0]          epoch_count,
    output logic                converged,
    output logic                done
);

    localparam int SW = 2 * W + 2;
    localparam logic [7:0] EPOCH_LEN_B  = 8'(EPOCH_LEN);
    localparam logic [7:0] MAX_EPOCHS_B = 8'(MAX_EPOCHS);
    localparam logic signed [SW-1:0] SUM_ZERO = '0;
    localparam logic signed [W-1:0]  ONE_W    = W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_COMPUTE,
        S_UPDATE,
        S_EPOCH_END,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic signed [W-1:0] w1_q, w1_d;
    logic signed [W-1:0] w2_q, w2_d;
    logic signed [W-1:0] bias_q, bias_d;
    logic [7:0]          smp_cnt_q, smp_cnt_d;
    logic [7:0]          err_cnt_q, err_cnt_d;
    logic [7:0]          ep_err_q, ep_err_d;
    logic [7:0]          ep_cnt_q, ep_cnt_d;
    logic                conv_q, conv_d;
    logic                done_q, done_d;

    // Sample and error registers carry data only, so they are not reset.
    logic signed [W-1:0] x1_q, x2_q;
    logic                tgt_q;
    logic                err_nz_q, err_pos_q;

    logic signed [SW-1:0] x1_e, x2_e, w1_e, w2_e, b_e, sum_c;
    logic                 y_c;
    logic signed [W-1:0]  dx1_c, dx2_c;

    // Add or subtract a step, then wrap or saturate back to W bits.
    function automatic logic signed [W-1:0] step_w(
        input logic signed [W-1:0] w,
        input logic signed [W-1:0] d,
        input logic                pos
    );
        logic signed [W:0] r;
        r = pos ? ($signed({w[W-1], w}) + $signed({d[W-1], d}))
                : ($signed({w[W-1], w}) - $signed({d[W-1], d}));
        return sat_w(r);
    endfunction

    function automatic logic signed [W-1:0] sat_w(input logic signed [W:0] r);
`ifdef PERCEPTRON_TRAINER_SAT_EN
        logic signed [W-1:0] res;
        if (r[W] != r[W-1]) begin
            res = r[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            res = r[W-1:0];
        end
        return res;
`else
        return r[W-1:0];
`endif
    endfunction

    // Full-precision dot product; every operand is sign-extended to SW bits first.
    assign x1_e  = SW'(x1_q);
    assign x2_e  = SW'(x2_q);
    assign w1_e  = SW'(w1_q);
    assign w2_e  = SW'(w2_q);
    assign b_e   = SW'(bias_q);
    assign sum_c = x1_e * w1_e + x2_e * w2_e + b_e;
    assign y_c   = (sum_c >= SUM_ZERO);
    assign dx1_c = x1_q >>> LR_SHIFT;
    assign dx2_c = x2_q >>> LR_SHIFT;

    always_comb begin
        state_d   = state_q;
        w1_d      = w1_q;
        w2_d      = w2_q;
        bias_d    = bias_q;
        smp_cnt_d = smp_cnt_q;
        err_cnt_d = err_cnt_q;
        ep_err_d  = ep_err_q;
        ep_cnt_d  = ep_cnt_q;
        conv_d    = conv_q;
        done_d    = done_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w1_d      = init_w1;
                    w2_d      = init_w2;
                    bias_d    = init_bias;
                    smp_cnt_d = '0;
                    err_cnt_d = '0;
                    ep_err_d  = '0;
                    ep_cnt_d  = '0;
                    conv_d    = 1'b0;
                    done_d    = 1'b0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (s_valid) begin
                    state_d = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                state_d = S_UPDATE;
            end
            S_UPDATE: begin
                if (err_nz_q) begin
                    w1_d   = step_w(w1_q, dx1_c, err_pos_q);
                    w2_d   = step_w(w2_q, dx2_c, err_pos_q);
                    bias_d = step_w(bias_q, ONE_W, err_pos_q);
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end
                smp_cnt_d = smp_cnt_q + 8'd1;
                state_d   = (smp_cnt_d == EPOCH_LEN_B) ? S_EPOCH_END : S_WAIT;
            end
            S_EPOCH_END: begin
                ep_err_d  = err_cnt_q;
                ep_cnt_d  = ep_cnt_q + 8'd1;
                err_cnt_d = '0;
                smp_cnt_d = '0;
                if (err_cnt_q == 8'd0) begin
                    conv_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (ep_cnt_d == MAX_EPOCHS_B) begin
                    conv_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            w1_q      <= '0;
            w2_q      <= '0;
            bias_q    <= '0;
            smp_cnt_q <= '0;
            err_cnt_q <= '0;
            ep_err_q  <= '0;
            ep_cnt_q  <= '0;
            conv_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            w1_q      <= w1_d;
            w2_q      <= w2_d;
            bias_q    <= bias_d;
            smp_cnt_q <= smp_cnt_d;
            err_cnt_q <= err_cnt_d;
            ep_err_q  <= ep_err_d;
            ep_cnt_q  <= ep_cnt_d;
            conv_q    <= conv_d;
            done_q    <= done_d;
        end
    end

    // Sample capture on transfer, error decision at the end of COMPUTE.
    always_ff @(posedge clk) begin
        if (state_q == S_WAIT && s_valid) begin
            x1_q  <= s_x1;
            x2_q  <= s_x2;
            tgt_q <= s_target;
        end
        if (state_q == S_COMPUTE) begin
            err_nz_q  <= (tgt_q != y_c);
            err_pos_q <= tgt_q;
        end
    end

    assign s_ready      = (state_q == S_WAIT);
    assign busy         = (state_q == S_WAIT) || (state_q == S_COMPUTE) ||
                          (state_q == S_UPDATE) || (state_q == S_EPOCH_END);
    assign epoch_done   = (state_q == S_EPOCH_END);
    assign w1           = w1_q;
    assign w2           = w2_q;
    assign bias         = bias_q;
    assign epoch_errors = ep_err_q;
    assign epoch_count  = ep_cnt_q;
    assign converged    = conv_q;
    assign done         = done_q;

endmodule
